// File: rtl/async_fifo_1clk_if.sv
// Handshake bundle between a FIFO user and async_fifo_1clk: write request/data,
// read request, and the registered full/empty flags and read data.
interface async_fifo_1clk_if #(
   parameter int Data_width = 8
);
   logic                  Winc;
   logic [Data_width-1:0] Wrdata;
   logic                  Rinc;
   logic                  Wfull;
   logic                  Rempty;
   logic [Data_width-1:0] Rdata;

   modport master (
      output Winc,
      output Wrdata,
      output Rinc,
      input  Wfull,
      input  Rempty,
      input  Rdata
   );

   modport slave (
      input  Winc,
      input  Wrdata,
      input  Rinc,
      output Wfull,
      output Rempty,
      output Rdata
   );
endinterface

// File: rtl/async_fifo_1clk.sv
// Single-clock core of the clock-crossing FIFO: Gray-coded pointers pass through
// NUM_STAGES synchronizer flops, so Wfull/Rempty are conservative as in the dual-clock version.
module async_fifo_1clk #(
   parameter int Data_width = 8,
   parameter int Depth      = 8,
   parameter int Address    = 3,
   parameter int NUM_STAGES = 2
) (
   input logic              Clk,
   input logic              Rst,
   async_fifo_1clk_if.slave bus
);

   localparam logic [Address:0] PtrOne = 1;

   function automatic logic [Address:0] bin2gray(input logic [Address:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [Address:0]      wbin_q, wbin_d;
   logic [Address:0]      wgray_q, wgray_d;
   logic [Address:0]      rbin_q, rbin_d;
   logic [Address:0]      rgray_q, rgray_d;
   logic [Address:0]      wsync_q [NUM_STAGES];
   logic [Address:0]      wsync_d [NUM_STAGES];
   logic [Address:0]      rsync_q [NUM_STAGES];
   logic [Address:0]      rsync_d [NUM_STAGES];
   logic [Data_width-1:0] rdata_q, rdata_d;
   logic                  wfull_q, wfull_d;
   logic                  rempty_q, rempty_d;
   logic [Data_width-1:0] mem_q [Depth];

   logic                  write_en;
   logic                  read_en;
   logic [Address:0]      wq_gray;
   logic [Address:0]      rq_gray;

   assign write_en = bus.Winc && !wfull_q;
   assign read_en  = bus.Rinc && !rempty_q;
   assign wq_gray  = wsync_q[NUM_STAGES-1];
   assign rq_gray  = rsync_q[NUM_STAGES-1];

   // Flags are computed from the post-edge pointers so they react on the same edge as the access.
   always_comb begin
      wbin_d   = wbin_q;
      wgray_d  = wgray_q;
      rbin_d   = rbin_q;
      rgray_d  = rgray_q;
      rdata_d  = rdata_q;
      if (write_en) begin
         wbin_d  = wbin_q + PtrOne;
         wgray_d = bin2gray(wbin_d);
      end
      if (read_en) begin
         rbin_d  = rbin_q + PtrOne;
         rgray_d = bin2gray(rbin_d);
         rdata_d = mem_q[rbin_q[Address-1:0]];
      end
      rempty_d = (rgray_d == wq_gray);
      wfull_d  = (wgray_d == {~rq_gray[Address:Address-1], rq_gray[Address-2:0]});
   end

   always_comb begin
      wsync_d[0] = wgray_q;
      rsync_d[0] = rgray_q;
      for (int i = 1; i < NUM_STAGES; i++) begin
         wsync_d[i] = wsync_q[i-1];
         rsync_d[i] = rsync_q[i-1];
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         wbin_q   <= '0;
         wgray_q  <= '0;
         rbin_q   <= '0;
         rgray_q  <= '0;
         rdata_q  <= '0;
         wfull_q  <= 1'b0;
         rempty_q <= 1'b1;
         for (int i = 0; i < NUM_STAGES; i++) begin
            wsync_q[i] <= '0;
            rsync_q[i] <= '0;
         end
      end else begin
         wbin_q   <= wbin_d;
         wgray_q  <= wgray_d;
         rbin_q   <= rbin_d;
         rgray_q  <= rgray_d;
         rdata_q  <= rdata_d;
         wfull_q  <= wfull_d;
         rempty_q <= rempty_d;
         for (int i = 0; i < NUM_STAGES; i++) begin
            wsync_q[i] <= wsync_d[i];
            rsync_q[i] <= rsync_d[i];
         end
      end
   end

   // Storage has no reset; writes are suppressed while Rst is low.
   always_ff @(posedge Clk) begin
      if (Rst && write_en) begin
         mem_q[wbin_q[Address-1:0]] <= bus.Wrdata;
      end
   end

   assign bus.Wfull  = wfull_q;
   assign bus.Rempty = rempty_q;
   assign bus.Rdata  = rdata_q;

endmodule

// File: tb/tb_async_fifo_1clk.sv
// Directed self-checking bench for async_fifo_1clk: fill/overflow, drain/underflow,
// interleaved traffic, pointer wrap and mid-stream reset.
module tb_async_fifo_1clk;

   logic Clk;
   logic Rst;
   int   total;
   int   bad;

   async_fifo_1clk_if #(.Data_width(8)) bus ();

   async_fifo_1clk #(
      .Data_width(8),
      .Depth     (8),
      .Address   (3),
      .NUM_STAGES(2)
   ) dut (
      .Clk(Clk),
      .Rst(Rst),
      .bus(bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // One clock edge with the given requests driven; outputs are settled on return.
   task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r);
      @(negedge Clk);
      bus.Winc   = w;
      bus.Wrdata = d;
      bus.Rinc   = r;
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
   endtask

   task automatic applyReset();
      @(negedge Clk);
      Rst        = 1'b0;
      bus.Winc   = 1'b0;
      bus.Rinc   = 1'b0;
      @(posedge Clk);
      #1;
      @(negedge Clk);
      Rst = 1'b1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      total      = 0;
      bad        = 0;
      Rst        = 1'b1;
      bus.Winc   = 1'b0;
      bus.Wrdata = 8'h00;
      bus.Rinc   = 1'b0;

      // Reset state
      applyReset();
      checkOutput("reset_rempty", 32'(bus.Rempty), 32'd1);
      checkOutput("reset_wfull", 32'(bus.Wfull), 32'd0);
      checkOutput("reset_rdata", 32'(bus.Rdata), 32'd0);

      // Fill with 11..18; Rempty clears 3 edges after the first write
      applyStimulus(1'b1, 8'd11, 1'b0);
      applyStimulus(1'b1, 8'd12, 1'b0);
      applyStimulus(1'b1, 8'd13, 1'b0);
      checkOutput("fill_rempty_w3", 32'(bus.Rempty), 32'd1);
      applyStimulus(1'b1, 8'd14, 1'b0);
      checkOutput("fill_rempty_w4", 32'(bus.Rempty), 32'd0);
      applyStimulus(1'b1, 8'd15, 1'b0);
      applyStimulus(1'b1, 8'd16, 1'b0);
      applyStimulus(1'b1, 8'd17, 1'b0);
      checkOutput("fill_wfull_w7", 32'(bus.Wfull), 32'd0);
      applyStimulus(1'b1, 8'd18, 1'b0);
      checkOutput("fill_wfull_w8", 32'(bus.Wfull), 32'd1);
      checkOutput("fill_rempty_w8", 32'(bus.Rempty), 32'd0);

      // Overflow write is dropped
      applyStimulus(1'b1, 8'd20, 1'b0);
      checkOutput("ovf_wfull", 32'(bus.Wfull), 32'd1);
      idle(2);
      checkOutput("ovf_wfull_idle", 32'(bus.Wfull), 32'd1);

      // Drain; Wfull clears 3 edges after the first read
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("drain_rd1", 32'(bus.Rdata), 32'd11);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("drain_rd2", 32'(bus.Rdata), 32'd12);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("drain_rd3", 32'(bus.Rdata), 32'd13);
      checkOutput("drain_wfull_r3", 32'(bus.Wfull), 32'd1);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("drain_rd4", 32'(bus.Rdata), 32'd14);
      checkOutput("drain_wfull_r4", 32'(bus.Wfull), 32'd0);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("drain_rd5", 32'(bus.Rdata), 32'd15);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("drain_rd6", 32'(bus.Rdata), 32'd16);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("drain_rd7", 32'(bus.Rdata), 32'd17);
      checkOutput("drain_rempty_r7", 32'(bus.Rempty), 32'd0);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("drain_rd8", 32'(bus.Rdata), 32'd18);
      checkOutput("drain_rempty_r8", 32'(bus.Rempty), 32'd1);

      // Underflow read: Rdata holds
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("udf_rdata", 32'(bus.Rdata), 32'd18);
      checkOutput("udf_rempty", 32'(bus.Rempty), 32'd1);
      idle(3);
      checkOutput("udf_wfull", 32'(bus.Wfull), 32'd0);

      // Interleaved traffic 51..58
      applyReset();
      checkOutput("il_reset_rempty", 32'(bus.Rempty), 32'd1);
      applyStimulus(1'b1, 8'd51, 1'b0);
      applyStimulus(1'b1, 8'd52, 1'b0);
      applyStimulus(1'b1, 8'd53, 1'b0);
      applyStimulus(1'b1, 8'd54, 1'b0);
      idle(3);
      applyStimulus(1'b1, 8'd55, 1'b1);
      checkOutput("il_rd1", 32'(bus.Rdata), 32'd51);
      applyStimulus(1'b1, 8'd56, 1'b1);
      checkOutput("il_rd2", 32'(bus.Rdata), 32'd52);
      applyStimulus(1'b1, 8'd57, 1'b1);
      checkOutput("il_rd3", 32'(bus.Rdata), 32'd53);
      applyStimulus(1'b1, 8'd58, 1'b1);
      checkOutput("il_rd4", 32'(bus.Rdata), 32'd54);
      idle(3);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("il_rd5", 32'(bus.Rdata), 32'd55);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("il_rd6", 32'(bus.Rdata), 32'd56);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("il_rd7", 32'(bus.Rdata), 32'd57);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("il_rd8", 32'(bus.Rdata), 32'd58);
      checkOutput("il_end_rempty", 32'(bus.Rempty), 32'd1);
      checkOutput("il_end_wfull", 32'(bus.Wfull), 32'd0);

      // 20 write/read pairs cross the 16-increment pointer wrap
      applyReset();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b1, 8'(100 + i), 1'b0);
         idle(3);
         checkOutput($sformatf("wrap_rempty_pre%0d", i), 32'(bus.Rempty), 32'd0);
         applyStimulus(1'b0, 8'd0, 1'b1);
         checkOutput($sformatf("wrap_rd%0d", i), 32'(bus.Rdata), 32'(100 + i));
         checkOutput($sformatf("wrap_rempty_post%0d", i), 32'(bus.Rempty), 32'd1);
      end

      // Mid-stream reset discards 200..202
      applyStimulus(1'b1, 8'd200, 1'b0);
      applyStimulus(1'b1, 8'd201, 1'b0);
      applyStimulus(1'b1, 8'd202, 1'b0);
      idle(3);
      checkOutput("mr_pre_rempty", 32'(bus.Rempty), 32'd0);
      applyReset();
      checkOutput("mr_rempty", 32'(bus.Rempty), 32'd1);
      checkOutput("mr_wfull", 32'(bus.Wfull), 32'd0);
      checkOutput("mr_rdata", 32'(bus.Rdata), 32'd0);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("mr_rd_empty_rdata", 32'(bus.Rdata), 32'd0);
      idle(4);
      checkOutput("mr_rempty_idle", 32'(bus.Rempty), 32'd1);
      applyStimulus(1'b1, 8'd210, 1'b0);
      idle(3);
      applyStimulus(1'b0, 8'd0, 1'b1);
      checkOutput("mr_rd_fresh", 32'(bus.Rdata), 32'd210);
      checkOutput("mr_end_rempty", 32'(bus.Rempty), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
